if_id_skid: RTL and testbench

//  Parametrised IF->ID pipeline register with valid/ready handshake and 2-entry skid buffer.

---
 rtl/if_id_skid.sv | 116 +++++++++++
 tb/tb_if_id_skid.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Never drops or duplicates a beat; supports synchronous flush and a saturating stall counter.
module if_id_skid #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic [DATA_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [DATA_W-1:0] out_inst_o,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              m_valid_q, m_valid_d;
  logic [ADDR_W-1:0] m_pc_q, m_pc_d;
  logic [DATA_W-1:0] m_inst_q, m_inst_d;
  logic              s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] s_pc_q, s_pc_d;
  logic [DATA_W-1:0] s_inst_q, s_inst_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic acc;
  logic pop;

  // in_ready comes straight from a flop, so there is no path from out_ready.
  assign in_ready_o     = ~s_valid_q;
  assign acc            = in_valid_i & in_ready_o;
  assign pop            = m_valid_q & out_ready_i;
  assign out_valid_o    = m_valid_q;
  assign out_pc_o       = m_pc_q;
  assign out_inst_o     = m_inst_q;
  assign stall_cycles_o = stall_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_inst_d  = m_inst_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_inst_d  = s_inst_q;

    if (flush_i) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_inst_d  = '0;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_inst_d  = '0;
    end else if (!m_valid_q) begin
      if (acc) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc_i;
        m_inst_d  = in_inst_i;
      end
    end else if (pop) begin
      if (s_valid_q) begin
        m_pc_d    = s_pc_q;
        m_inst_d  = s_inst_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_pc_d   = in_pc_i;
        m_inst_d = in_inst_i;
      end else begin
        m_valid_d = 1'b0;
        // A bubble reads as all-zero downstream when ZERO_BUBBLE is set.
        if (ZERO_BUBBLE) begin
          m_pc_d   = '0;
          m_inst_d = '0;
        end
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_pc_d    = in_pc_i;
      s_inst_d  = in_inst_i;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (m_valid_q && !out_ready_i && !flush_i && (stall_q != CntMax)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_inst_q  <= '0;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_inst_q  <= '0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_inst_q  <= m_inst_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_inst_q  <= s_inst_d;
      stall_q   <= stall_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios then random traffic, compared against a
// FIFO-queue reference model with a saturating stall count.
module tb_if_id_skid;

  localparam int CW = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   in_pc_i;
  logic [31:0]   in_inst_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_pc_o;
  logic [31:0]   out_inst_o;
  logic          flush_i;
  logic [CW-1:0] stall_cycles_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  beat_t modelQ[$];
  int    modelStall;
  int    assertCount;
  int    failCount;

  if_id_skid #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(CW), .ZERO_BUBBLE(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .flush_i(flush_i), .stall_cycles_o(stall_cycles_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs come from the queue: head is what decode sees, full queue blocks fetch.
  task automatic checkOutput(input string tag);
    logic [31:0] expPc;
    logic [31:0] expInst;
    expPc   = (modelQ.size() > 0) ? modelQ[0].pc   : 32'h0;
    expInst = (modelQ.size() > 0) ? modelQ[0].inst : 32'h0;
    checkValue({tag, ".out_valid"}, {31'h0, out_valid_o}, {31'h0, modelQ.size() > 0});
    checkValue({tag, ".in_ready"}, {31'h0, in_ready_o}, {31'h0, modelQ.size() < 2});
    checkValue({tag, ".out_pc"}, out_pc_o, expPc);
    checkValue({tag, ".out_inst"}, out_inst_o, expInst);
    checkValue({tag, ".stall"}, {{(32-CW){1'b0}}, stall_cycles_o}, modelStall);
  endtask

  task automatic resetModel();
    modelQ.delete();
    modelStall = 0;
  endtask

  // Drive one cycle of inputs after a falling edge, advance the model at the rising edge,
  // then compare at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic rdy, input logic fl, input string tag);
    bit    canAccept;
    bit    doPop;
    beat_t b;
    in_valid_i  = v;
    in_pc_i     = pc;
    in_inst_i   = inst;
    out_ready_i = rdy;
    flush_i     = fl;
    @(posedge clk_i);
    canAccept = (modelQ.size() < 2);
    doPop     = (modelQ.size() > 0) && rdy;
    if ((modelQ.size() > 0) && !rdy && !fl && modelStall < (2**CW - 1)) modelStall++;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (doPop) void'(modelQ.pop_front());
      if (v && canAccept) begin
        b.pc   = pc;
        b.inst = inst;
        modelQ.push_back(b);
      end
    end
    @(negedge clk_i);
    checkOutput(tag);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_pc_i     = '0;
    in_inst_i   = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    resetModel();

    // Reset values, then release
    @(negedge clk_i);
    checkOutput("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("release");

    // Full-throughput stream
    applyStimulus(1, 32'h100, 32'hA100, 1, 0, "stream0");
    applyStimulus(1, 32'h104, 32'hA104, 1, 0, "stream1");
    applyStimulus(1, 32'h108, 32'hA108, 1, 0, "stream2");
    applyStimulus(0, 32'h0,   32'h0,    1, 0, "stream_drain");
    checkValue("stream_empty", {31'h0, out_valid_o}, 32'h0);

    // Back-pressure into the skid
    applyStimulus(1, 32'h100, 32'hB100, 0, 0, "bp_load");
    applyStimulus(1, 32'h104, 32'hB104, 0, 0, "bp_skid");
    checkValue("bp_in_ready_low", {31'h0, in_ready_o}, 32'h0);
    applyStimulus(1, 32'h1FC, 32'hBFFC, 0, 0, "bp_hold");
    checkValue("bp_hold_pc", out_pc_o, 32'h100);
    applyStimulus(0, 32'h0,   32'h0,    1, 0, "bp_release");
    checkValue("bp_next_pc", out_pc_o, 32'h104);
    checkValue("bp_ready_back", {31'h0, in_ready_o}, 32'h1);
    applyStimulus(0, 32'h0,   32'h0,    1, 0, "bp_drain");

    // Flush with both entries occupied and a beat on the input
    applyStimulus(1, 32'h200, 32'hC200, 0, 0, "fl_main");
    applyStimulus(1, 32'h204, 32'hC204, 0, 0, "fl_skid");
    applyStimulus(1, 32'h208, 32'hC208, 0, 1, "flush");
    checkValue("flush_inst", out_inst_o, 32'h0);
    applyStimulus(0, 32'h0,   32'h0,    1, 0, "post_flush");

    // Counter saturation from a clean reset
    rst_ni = 1'b0;
    resetModel();
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1, 32'h300, 32'hD300, 0, 0, "sat_load");
    for (int i = 0; i < 20; i++) applyStimulus(0, 32'h0, 32'h0, 0, 0, "sat");
    checkValue("sat_value", {{(32-CW){1'b0}}, stall_cycles_o}, 32'd15);
    applyStimulus(0, 32'h0, 32'h0, 1, 1, "sat_flush");
    checkValue("sat_kept_by_flush", {{(32-CW){1'b0}}, stall_cycles_o}, 32'd15);

    // Asynchronous reset between edges with the skid full
    applyStimulus(1, 32'h400, 32'hE400, 0, 0, "ar_main");
    applyStimulus(1, 32'h404, 32'hE404, 0, 0, "ar_skid");
    #2;
    rst_ni = 1'b0;
    resetModel();
    #1;
    checkOutput("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ar_release");
    applyStimulus(1, 32'h500, 32'hF500, 1, 0, "ar_first");
    checkValue("ar_first_pc", out_pc_o, 32'h500);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
